// File: rtl/mac_dot_pkg.sv
// Shared widths and FSM state encoding for the dot-product MAC sequencer.
package mac_dot_pkg;

  localparam int DATA_W = 14;
  localparam int ACC_W  = 28;
  localparam int ADDR_W = 10;
  localparam int LEN_W  = 11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ISSUE = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/mac_dot_seq.sv
// Dot-product sequencer: clears an external pipelined MAC, streams operand pairs
// from two 1-cycle-latency memories into it, and returns the final accumulator.
module mac_dot_seq #(
  parameter int DATA_W = mac_dot_pkg::DATA_W,
  parameter int ACC_W  = mac_dot_pkg::ACC_W,
  parameter int ADDR_W = mac_dot_pkg::ADDR_W,
  parameter int LEN_W  = mac_dot_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [LEN_W-1:0]  job_len,
  input  logic [ADDR_W-1:0] job_base_a,
  input  logic [ADDR_W-1:0] job_base_b,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_a_addr,
  output logic [ADDR_W-1:0] mem_b_addr,
  input  logic [DATA_W-1:0] mem_a_data,
  input  logic [DATA_W-1:0] mem_b_data,
  output logic              mac_clear,
  output logic              mac_valid_in,
  output logic [DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0] mac_b,
  input  logic [ACC_W-1:0]  mac_f,
  input  logic              mac_valid_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data
);
  import mac_dot_pkg::*;

  state_t            state_r;
  state_t            next_state;
  logic [LEN_W-1:0]  len_r;
  logic [LEN_W-1:0]  issue_cnt_r;
  logic [LEN_W-1:0]  out_cnt_r;
  logic [LEN_W-1:0]  out_cnt_nxt;
  logic [ADDR_W-1:0] base_a_r;
  logic [ADDR_W-1:0] base_b_r;
  logic [ADDR_W-1:0] addr_a_r;
  logic [ADDR_W-1:0] addr_b_r;
  logic [ACC_W-1:0]  res_data_r;
  logic              job_ready_r;
  logic              res_valid_r;
  logic              mac_clear_r;
  logic              mem_rd_en_r;
  logic              mac_valid_in_r;
  logic              job_take;
  logic              last_issue;
  logic              last_out;

  // Handshake decode and next-state selection.
  always_comb begin
    out_cnt_nxt = out_cnt_r + LEN_W'(1);
    job_take    = job_valid && job_ready_r;
    last_issue  = (issue_cnt_r == (len_r - LEN_W'(1)));
    last_out    = mac_valid_out && (out_cnt_nxt == len_r);
    next_state  = state_r;
    case (state_r)
      IDLE: begin
        if (job_take) begin
          next_state = (job_len == LEN_W'(0)) ? DONE : CLEAR;
        end else begin
          next_state = IDLE;
        end
      end
      CLEAR: next_state = ISSUE;
      ISSUE: begin
        if (last_out) begin
          next_state = DONE;
        end else if (last_issue) begin
          next_state = DRAIN;
        end else begin
          next_state = ISSUE;
        end
      end
      DRAIN: begin
        if (last_out) begin
          next_state = DONE;
        end else begin
          next_state = DRAIN;
        end
      end
      DONE: begin
        if (res_ready) begin
          next_state = IDLE;
        end else begin
          next_state = DONE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register; state-decoded outputs are registered from next_state so they
  // line up with the state itself. mac_clear resets high to purge the MAC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r        <= IDLE;
      job_ready_r    <= 1'b1;
      res_valid_r    <= 1'b0;
      mac_clear_r    <= 1'b1;
      mem_rd_en_r    <= 1'b0;
      mac_valid_in_r <= 1'b0;
    end else begin
      state_r        <= next_state;
      job_ready_r    <= (next_state == IDLE);
      res_valid_r    <= (next_state == DONE);
      mac_clear_r    <= (next_state == CLEAR);
      mem_rd_en_r    <= (next_state == ISSUE);
      mac_valid_in_r <= mem_rd_en_r;
    end
  end

  // Job latch, read address generation, output counting and result capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_r       <= LEN_W'(0);
      base_a_r    <= ADDR_W'(0);
      base_b_r    <= ADDR_W'(0);
      addr_a_r    <= ADDR_W'(0);
      addr_b_r    <= ADDR_W'(0);
      issue_cnt_r <= LEN_W'(0);
      out_cnt_r   <= LEN_W'(0);
      res_data_r  <= ACC_W'(0);
    end else begin
      case (state_r)
        IDLE: begin
          if (job_take) begin
            len_r       <= job_len;
            base_a_r    <= job_base_a;
            base_b_r    <= job_base_b;
            issue_cnt_r <= LEN_W'(0);
            out_cnt_r   <= LEN_W'(0);
            if (job_len == LEN_W'(0)) begin
              res_data_r <= ACC_W'(0);
            end
          end
        end
        CLEAR: begin
          addr_a_r <= base_a_r;
          addr_b_r <= base_b_r;
        end
        ISSUE: begin
          addr_a_r    <= addr_a_r + ADDR_W'(1);
          addr_b_r    <= addr_b_r + ADDR_W'(1);
          issue_cnt_r <= issue_cnt_r + LEN_W'(1);
        end
        default: begin
        end
      endcase
      // MAC outputs can already arrive while reads are still being issued.
      if (((state_r == ISSUE) || (state_r == DRAIN)) && mac_valid_out) begin
        out_cnt_r <= out_cnt_nxt;
        if (out_cnt_nxt == len_r) begin
          res_data_r <= mac_f;
        end
      end
    end
  end

  assign job_ready    = job_ready_r;
  assign res_valid    = res_valid_r;
  assign res_data     = res_data_r;
  assign mac_clear    = mac_clear_r;
  assign mem_rd_en    = mem_rd_en_r;
  assign mem_a_addr   = addr_a_r;
  assign mem_b_addr   = addr_b_r;
  assign mac_valid_in = mac_valid_in_r;
  assign mac_a        = mem_a_data;
  assign mac_b        = mem_b_data;

endmodule

// File: tb/tb_mac_dot_seq.sv
// Bench for mac_dot_seq: stand-in memories and a 2-stage signed MAC, with results
// compared against a plain-arithmetic dot product over the memory contents.
module tb_mac_dot_seq;

  logic               clk = 1'b0;
  logic               reset;
  logic               job_valid;
  logic               job_ready;
  logic [10:0]        job_len;
  logic [9:0]         job_base_a;
  logic [9:0]         job_base_b;
  logic               mem_rd_en;
  logic [9:0]         mem_a_addr;
  logic [9:0]         mem_b_addr;
  logic [13:0]        mem_a_data;
  logic [13:0]        mem_b_data;
  logic               mac_clear;
  logic               mac_valid_in;
  logic signed [13:0] mac_a;
  logic signed [13:0] mac_b;
  logic signed [27:0] mac_f;
  logic               mac_valid_out;
  logic               res_valid;
  logic               res_ready;
  logic [27:0]        res_data;

  logic signed [13:0] mem_a [0:1023];
  logic signed [13:0] mem_b [0:1023];

  int checks   = 0;
  int failures = 0;

  mac_dot_seq dut (
    .clk(clk), .reset(reset),
    .job_valid(job_valid), .job_ready(job_ready), .job_len(job_len),
    .job_base_a(job_base_a), .job_base_b(job_base_b),
    .mem_rd_en(mem_rd_en), .mem_a_addr(mem_a_addr), .mem_b_addr(mem_b_addr),
    .mem_a_data(mem_a_data), .mem_b_data(mem_b_data),
    .mac_clear(mac_clear), .mac_valid_in(mac_valid_in), .mac_a(mac_a), .mac_b(mac_b),
    .mac_f(mac_f), .mac_valid_out(mac_valid_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  always #5 clk = ~clk;

  // 1-cycle-latency operand memories.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_a_data <= mem_a[mem_a_addr];
      mem_b_data <= mem_b[mem_b_addr];
    end
  end

  // Stand-in MAC: multiply stage, then accumulate stage; synchronous clear.
  logic signed [27:0] prod;
  logic               prod_v;
  always @(posedge clk) begin
    if (mac_clear) begin
      prod <= 28'sd0; prod_v <= 1'b0; mac_f <= 28'sd0; mac_valid_out <= 1'b0;
    end else begin
      prod          <= mac_a * mac_b;
      prod_v        <= mac_valid_in;
      mac_valid_out <= prod_v;
      if (prod_v) mac_f <= mac_f + prod;
    end
  end

  // Passive monitor sampled on the falling edge.
  int         cyc = 0, rd_cnt = 0, clr_cnt = 0, rd_runs = 0, last_vo_cyc = 0, res_rise_cyc = 0;
  logic       prev_rd = 1'b0, prev_rv = 1'b0;
  logic [9:0] a_log[$];
  logic [9:0] b_log[$];
  always @(negedge clk) begin
    cyc <= cyc + 1;
    prev_rd <= mem_rd_en;
    prev_rv <= res_valid;
    if (reset && mac_clear) clr_cnt <= clr_cnt + 1;
    if (mem_rd_en) begin
      rd_cnt <= rd_cnt + 1;
      a_log.push_back(mem_a_addr);
      b_log.push_back(mem_b_addr);
      if (!prev_rd) rd_runs <= rd_runs + 1;
    end
    if (mac_valid_out) last_vo_cyc <= cyc;
    if (res_valid && !prev_rv) res_rise_cyc <= cyc;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [27:0] ref_dot(input int len, input int ba, input int bb);
    longint s = 0;
    for (int k = 0; k < len; k++)
      s += longint'(mem_a[(ba + k) % 1024]) * longint'(mem_b[(bb + k) % 1024]);
    return s[27:0];
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic run_job(input int len, input int ba, input int bb, input int hold,
                         output logic [27:0] got);
    logic [27:0] want;
    int rd0, clr0, runs0, n0, n, bad;
    want  = ref_dot(len, ba, bb);
    rd0   = rd_cnt; clr0 = clr_cnt; runs0 = rd_runs; n0 = a_log.size();
    chk("job_ready_idle", {63'd0, job_ready}, 64'd1);
    job_valid = 1'b1; job_len = 11'(len); job_base_a = 10'(ba); job_base_b = 10'(bb);
    step();
    job_valid = 1'b0;
    n = 0;
    while (!res_valid && n < 5000) begin step(); n++; end
    chk("res_timeout", {63'd0, (n < 5000)}, 64'd1);
    @(negedge clk); #1;
    got = res_data;
    chk("res_data", {36'd0, res_data}, {36'd0, want});
    chk("rd_count", 64'(rd_cnt - rd0), 64'(len));
    chk("clear_pulses", 64'(clr_cnt - clr0), 64'((len != 0) ? 1 : 0));
    chk("rd_runs", 64'(rd_runs - runs0), 64'((len != 0) ? 1 : 0));
    if (len != 0) chk("res_latency", 64'(res_rise_cyc - last_vo_cyc), 64'd1);
    bad = 0;
    for (int k = 0; k < len; k++) begin
      if (a_log[n0 + k] !== 10'((ba + k) % 1024)) bad++;
      if (b_log[n0 + k] !== 10'((bb + k) % 1024)) bad++;
    end
    chk("addr_seq", 64'(bad), 64'd0);
    chk("job_ready_busy", {63'd0, job_ready}, 64'd0);
    step();
    for (int h = 0; h < hold; h++) begin
      job_valid = 1'b1; job_len = 11'd3;
      chk("bp_res_valid", {63'd0, res_valid}, 64'd1);
      chk("bp_res_data", {36'd0, res_data}, {36'd0, want});
      chk("bp_job_ready", {63'd0, job_ready}, 64'd0);
      step();
    end
    job_valid = 1'b0;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("res_valid_drop", {63'd0, res_valid}, 64'd0);
    chk("job_ready_back", {63'd0, job_ready}, 64'd1);
  endtask

  logic [27:0] got;
  int          n0, ba, bb, ln;

  initial begin
    reset = 1'b0; job_valid = 1'b0; job_len = 11'd0; job_base_a = 10'd0; job_base_b = 10'd0;
    res_ready = 1'b0;
    for (int i = 0; i < 1024; i++) begin mem_a[i] = 14'sd0; mem_b[i] = 14'sd0; end
    repeat (3) step();
    chk("rst_job_ready", {63'd0, job_ready}, 64'd1);
    chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
    chk("rst_res_data", {36'd0, res_data}, 64'd0);
    chk("rst_rd_en", {63'd0, mem_rd_en}, 64'd0);
    chk("rst_valid_in", {63'd0, mac_valid_in}, 64'd0);
    chk("rst_clear", {63'd0, mac_clear}, 64'd1);
    chk("rst_addr", {54'd0, mem_a_addr}, 64'd0);
    reset = 1'b1;
    repeat (2) step();
    chk("idle_clear_low", {63'd0, mac_clear}, 64'd0);

    mem_a[0] = 14'sd1; mem_a[1] = 14'sd2; mem_a[2] = 14'sd3; mem_a[3] = 14'sd4;
    mem_b[16] = 14'sd5; mem_b[17] = 14'sd6; mem_b[18] = 14'sd7; mem_b[19] = 14'sd8;
    run_job(4, 0, 16, 0, got);
    chk("dot_basic_70", {36'd0, got}, 64'd70);

    mem_a[32] = -14'sd8192; mem_a[33] = 14'sd8191;
    mem_b[48] = -14'sd8192; mem_b[49] = -14'sd8192;
    run_job(2, 32, 48, 0, got);
    chk("dot_extremes", {36'd0, got}, 64'h2000);

    run_job(0, 5, 5, 0, got);
    chk("dot_len0", {36'd0, got}, 64'd0);

    // Backpressure on a random job
    ba = int'($urandom_range(0, 1023)); bb = int'($urandom_range(0, 1023));
    for (int k = 0; k < 7; k++) begin
      mem_a[(ba + k) % 1024] = 14'($urandom); mem_b[(bb + k) % 1024] = 14'($urandom);
    end
    run_job(7, ba, bb, 10, got);

    // Address wrap on the A side
    bb = int'($urandom_range(0, 1023));
    for (int k = 0; k < 4; k++) begin
      mem_a[(1022 + k) % 1024] = 14'($urandom); mem_b[(bb + k) % 1024] = 14'($urandom);
    end
    n0 = a_log.size();
    run_job(4, 1022, bb, 0, got);
    chk("wrap_a0", {54'd0, a_log[n0]}, 64'h3FE);
    chk("wrap_a1", {54'd0, a_log[n0 + 1]}, 64'h3FF);
    chk("wrap_a2", {54'd0, a_log[n0 + 2]}, 64'h000);
    chk("wrap_a3", {54'd0, a_log[n0 + 3]}, 64'h001);

    // Random jobs
    for (int j = 0; j < 6; j++) begin
      ln = int'($urandom_range(1, 40));
      ba = int'($urandom_range(0, 1023)); bb = int'($urandom_range(0, 1023));
      for (int k = 0; k < ln; k++) begin
        mem_a[(ba + k) % 1024] = 14'($urandom); mem_b[(bb + k) % 1024] = 14'($urandom);
      end
      run_job(ln, ba, bb, int'($urandom_range(0, 3)), got);
    end

    // Reset in the middle of ISSUE on a len=8 job
    for (int k = 0; k < 8; k++) begin
      mem_a[100 + k] = 14'($urandom); mem_b[200 + k] = 14'($urandom);
    end
    job_valid = 1'b1; job_len = 11'd8; job_base_a = 10'd100; job_base_b = 10'd200;
    step();
    job_valid = 1'b0;
    repeat (3) step();
    chk("mid_issue_rd", {63'd0, mem_rd_en}, 64'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_clear", {63'd0, mac_clear}, 64'd1);
    chk("mid_rst_rd_en", {63'd0, mem_rd_en}, 64'd0);
    chk("mid_rst_valid_in", {63'd0, mac_valid_in}, 64'd0);
    chk("mid_rst_res_valid", {63'd0, res_valid}, 64'd0);
    repeat (3) step();
    chk("mid_rst_clear_hold", {63'd0, mac_clear}, 64'd1);
    reset = 1'b1;
    repeat (12) step();
    chk("no_stale_result", {63'd0, res_valid}, 64'd0);
    mem_a[300] = 14'sd3; mem_a[301] = 14'sd4; mem_b[400] = 14'sd2; mem_b[401] = 14'sd2;
    run_job(2, 300, 400, 0, got);
    chk("after_reset_14", {36'd0, got}, 64'd14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
